rolhadora_controller: RTL and testbench
=======================================

// Module: rolhadora_controller
// PURPOSE
//  Sequences the corking station around the cork-stock down-counter (7-bit, reset value 99, ZERO flag).
//  Detects a bottle, lets it settle, fires the corking actuator, pulses the counter ENABLE once per cork,
//  then releases the belt. Stops the line with an alarm when stock hits zero.
//  Drives the counter LOAD/DADOS path on operator refill.
// PARAMETERS
//  SETTLE_CYCLES  4    cycles SENSOR_GARRAFA must stay high before corking
//  CORK_CYCLES    8    cycles ATUADOR is held high per bottle
//  WDOG_CYCLES    255  max cycles in LIBERA before fault (ROLHA_WATCHDOG_EN only)
//  MAX_ROLHAS     99   refill value used when QTD_REPOR is out of range
// PORTS
//  CLOCK           in   1   system clock, rising edge
//  RESET           in   1   asynchronous, active-high
//  SENSOR_GARRAFA  in   1   bottle present at corking position
//  CNT_ZERO        in   1   ZERO flag from cork counter
//  REPOR           in   1   operator refill request, level, sampled
//  QTD_REPOR       in   7   corks loaded on refill
//  CNT_ENABLE      out  1   decrement strobe to counter
//  CNT_LOAD        out  1   load strobe to counter
//  CNT_DADOS       out  7   load value to counter
//  MOTOR_ESTEIRA   out  1   belt motor run
//  ATUADOR         out  1   corking press
//  ALARME          out  1   stock empty, line stopped
//  FALHA           out  1   bottle jam fault (0 when watchdog compiled out)
//  GARRAFAS_OK     out  16  bottles corked since reset, saturates at 16'hFFFF
// BEHAVIOUR
//  - All outputs registered (Moore). On RESET: state IDLE, every output 0, GARRAFAS_OK=0, timer=0.
//  - IDLE: MOTOR=1. Transition priority is CNT_ZERO -> ALARME, REPOR -> RECARGA, SENSOR_GARRAFA -> POSICIONA.
//    MOTOR is high from the first edge after RESET release.
//  - POSICIONA: MOTOR=0; timer loads SETTLE_CYCLES.
//    Sensor low before expiry -> IDLE (glitch, no cork used). Expiry with sensor high -> ARROLHA.
//  - ARROLHA: ATUADOR=1 for exactly CORK_CYCLES cycles -> DECREMENTA.
//  - DECREMENTA: CNT_ENABLE=1 for exactly one cycle. GARRAFAS_OK += 1 (saturating) -> LIBERA.
//    The counter value changes on the edge that ends this cycle.
//  - LIBERA: MOTOR=1; wait for SENSOR_GARRAFA=0 -> IDLE.
//    The next bottle needs a rising sensor edge in IDLE. A level still high on entry to IDLE is ignored.
//  - ALARME: ALARME=1, MOTOR=0. Only REPOR=1 -> RECARGA. The ZERO flag alone never clears ALARME.
//  - RECARGA: one cycle with CNT_LOAD=1 and CNT_DADOS=QTD_REPOR latched at entry.
//    If QTD_REPOR==0 or >MAX_ROLHAS, load MAX_ROLHAS. CNT_ENABLE=0 in this cycle. Next state IDLE.
//  - CNT_ENABLE and CNT_LOAD are never high together. CNT_DADOS is 0 outside RECARGA.
//  - Stock reaching 0 mid-bottle: the current bottle completes LIBERA, then IDLE routes to ALARME.
//  - REPOR outside IDLE/ALARME is ignored. It is not queued.
//  - RESET mid-operation: immediate return to IDLE, ATUADOR drops asynchronously, and GARRAFAS_OK clears.
//    The counter keeps its own state; this block does not reload it.
// CONFIGURATION
//  ROLHA_WATCHDOG_EN defined:
//    LIBERA timer loads WDOG_CYCLES. Expiry with sensor still high -> FALHA state.
//    FALHA state drives FALHA=1, MOTOR=0, ATUADOR=0 and can only be left via RESET.
//  ROLHA_WATCHDOG_EN undefined:
//    LIBERA waits indefinitely. FALHA is tied to 0. No FALHA state is encoded.
// STRUCTURE
//  Package rolhadora_pkg holds:
//    - state encoding (IDLE, POSICIONA, ARROLHA, DECREMENTA, LIBERA, ALARME, RECARGA, FALHA)
//    - CNT_W=7 and MAX_ROLHAS=99
//    - timer width, sized to max(SETTLE, CORK, WDOG)
//  Sub-module temporizador_ciclos: loadable down-counter with load/value/expired ports.
//    One instance is shared by POSICIONA, ARROLHA and LIBERA.
//  The FSM and GARRAFAS_OK counter stay in this module.
// TESTING
//  1 Reset, counter at 99, one bottle (sensor high 20 cycles then low):
//    ATUADOR high 8 cycles, one CNT_ENABLE pulse, counter 98, GARRAFAS_OK=1.
//  2 Sensor high for 2 cycles only: back to IDLE with no ATUADOR and no CNT_ENABLE.
//    Counter stays 99.
//  3 Counter preloaded to 1, two bottles: the second bottle is not corked.
//    ALARME=1 and MOTOR=0 after the first LIBERA.
//  4 In ALARME, REPOR=1 with QTD_REPOR=50: one-cycle CNT_LOAD with CNT_DADOS=50, counter 50.
//    ALARME clears and the line resumes.
//  5 REPOR with QTD_REPOR=0, then separately with 120: both load 99.
//    REPOR asserted during ARROLHA produces no CNT_LOAD.
//  6 Watchdog on, sensor stuck high in LIBERA for 256 cycles: FALHA=1, MOTOR=0, held until RESET.
//    Watchdog off: stays in LIBERA with FALHA=0.

Source files
------------

// File: rtl/rolhadora_pkg.sv
// ============================================================================
// rolhadora_pkg : shared types and constants for the corking station controller
// Rev 1.0
// ============================================================================
`default_nettype none

package rolhadora_pkg;

   localparam int CNT_W         = 7;
   localparam int MAX_ROLHAS    = 99;
   localparam int SETTLE_CYCLES = 4;
   localparam int CORK_CYCLES   = 8;
   localparam int WDOG_CYCLES   = 255;

   localparam int TMR_MAX_A = (SETTLE_CYCLES > CORK_CYCLES) ? SETTLE_CYCLES : CORK_CYCLES;
   localparam int TMR_MAX   = (TMR_MAX_A > WDOG_CYCLES) ? TMR_MAX_A : WDOG_CYCLES;
   localparam int TMR_W     = $clog2(TMR_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_POSICIONA  = 3'd1,
      ST_ARROLHA    = 3'd2,
      ST_DECREMENTA = 3'd3,
      ST_LIBERA     = 3'd4,
      ST_ALARME     = 3'd5,
      ST_RECARGA    = 3'd6
`ifdef ROLHA_WATCHDOG_EN
      , ST_FALHA    = 3'd7
`endif
   } estado_t;

   // Out-of-range refill requests fall back to a full magazine.
   function automatic logic [CNT_W-1:0] valor_recarga(input logic [CNT_W-1:0] qtd);
      if (qtd == '0 || qtd > CNT_W'(MAX_ROLHAS)) begin
         return CNT_W'(MAX_ROLHAS);
      end
      return qtd;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rolhadora_controller_if.sv
// ============================================================================
// rolhadora_controller_if : station I/O bundle (sensor, counter path, actuators)
// Rev 1.0
// ============================================================================
`default_nettype none

interface rolhadora_controller_if;
   import rolhadora_pkg::*;

   logic             SENSOR_GARRAFA;
   logic             CNT_ZERO;
   logic             REPOR;
   logic [CNT_W-1:0] QTD_REPOR;
   logic             CNT_ENABLE;
   logic             CNT_LOAD;
   logic [CNT_W-1:0] CNT_DADOS;
   logic             MOTOR_ESTEIRA;
   logic             ATUADOR;
   logic             ALARME;
   logic             FALHA;
   logic [15:0]      GARRAFAS_OK;

   modport master (
      input  SENSOR_GARRAFA, CNT_ZERO, REPOR, QTD_REPOR,
      output CNT_ENABLE, CNT_LOAD, CNT_DADOS, MOTOR_ESTEIRA, ATUADOR, ALARME, FALHA, GARRAFAS_OK
   );

   modport slave (
      output SENSOR_GARRAFA, CNT_ZERO, REPOR, QTD_REPOR,
      input  CNT_ENABLE, CNT_LOAD, CNT_DADOS, MOTOR_ESTEIRA, ATUADOR, ALARME, FALHA, GARRAFAS_OK
   );

endinterface

`default_nettype wire

// File: rtl/rolhadora_controller_temporizador_ciclos.sv
// ============================================================================
// temporizador_ciclos : loadable down-counter, expired while the count is zero
// Rev 1.0
// ============================================================================
`default_nettype none

module temporizador_ciclos
   import rolhadora_pkg::*;
(
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             load,
   input  logic [TMR_W-1:0] value,
   output logic             expired
);

   logic [TMR_W-1:0] count_q;
   logic [TMR_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = value;
      end else if (count_q != '0) begin
         count_d = count_q - TMR_W'(1);
      end
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/rolhadora_controller.sv
// ============================================================================
// rolhadora_controller : corking station sequencer around the cork-stock counter
// Optional jam watchdog in LIBERA: define ROLHA_WATCHDOG_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module rolhadora_controller
   import rolhadora_pkg::*;
(
   input  logic                  CLOCK,
   input  logic                  RESET,
   rolhadora_controller_if.master bus
);

   estado_t          state_q, state_d;
   logic             sensor_prev_q, sensor_prev_d;
   logic [15:0]      garrafas_q, garrafas_d;
   logic             cnt_enable_q, cnt_enable_d;
   logic             cnt_load_q, cnt_load_d;
   logic [CNT_W-1:0] cnt_dados_q, cnt_dados_d;
   logic             motor_q, motor_d;
   logic             atuador_q, atuador_d;
   logic             alarme_q, alarme_d;
`ifdef ROLHA_WATCHDOG_EN
   logic             falha_q, falha_d;
`endif

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_value;
   logic             tmr_expired;
   logic             sensor_rise;

   temporizador_ciclos u_temporizador (
      .CLOCK   (CLOCK),
      .RESET   (RESET),
      .load    (tmr_load),
      .value   (tmr_value),
      .expired (tmr_expired)
   );

   assign sensor_rise = bus.SENSOR_GARRAFA & ~sensor_prev_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.CNT_ZERO)    state_d = ST_ALARME;
            else if (bus.REPOR)  state_d = ST_RECARGA;
            else if (sensor_rise) state_d = ST_POSICIONA;
         end
         ST_POSICIONA: begin
            if (!bus.SENSOR_GARRAFA) state_d = ST_IDLE;
            else if (tmr_expired)    state_d = ST_ARROLHA;
         end
         ST_ARROLHA: begin
            if (tmr_expired) state_d = ST_DECREMENTA;
         end
         ST_DECREMENTA: state_d = ST_LIBERA;
         ST_LIBERA: begin
            if (!bus.SENSOR_GARRAFA) state_d = ST_IDLE;
`ifdef ROLHA_WATCHDOG_EN
            else if (tmr_expired)    state_d = ST_FALHA;
`endif
         end
         ST_ALARME: begin
            if (bus.REPOR) state_d = ST_RECARGA;
         end
         ST_RECARGA: state_d = ST_IDLE;
`ifdef ROLHA_WATCHDOG_EN
         ST_FALHA: state_d = ST_FALHA;
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Timer is loaded with N-1 on the edge entering the state, so the state lasts N cycles.
   always_comb begin
      tmr_load  = 1'b0;
      tmr_value = '0;
      if (state_d != state_q) begin
         case (state_d)
            ST_POSICIONA: begin
               tmr_load  = 1'b1;
               tmr_value = TMR_W'(SETTLE_CYCLES - 1);
            end
            ST_ARROLHA: begin
               tmr_load  = 1'b1;
               tmr_value = TMR_W'(CORK_CYCLES - 1);
            end
`ifdef ROLHA_WATCHDOG_EN
            ST_LIBERA: begin
               tmr_load  = 1'b1;
               tmr_value = TMR_W'(WDOG_CYCLES - 1);
            end
`endif
            default: ;
         endcase
      end
   end

   // Outputs are decoded from the next state and registered, keeping them aligned with state_q.
   always_comb begin
      sensor_prev_d = bus.SENSOR_GARRAFA;
      motor_d       = (state_d == ST_IDLE) || (state_d == ST_LIBERA);
      atuador_d     = (state_d == ST_ARROLHA);
      cnt_enable_d  = (state_d == ST_DECREMENTA);
      cnt_load_d    = (state_d == ST_RECARGA);
      cnt_dados_d   = (state_d == ST_RECARGA) ? valor_recarga(bus.QTD_REPOR) : '0;
      alarme_d      = (state_d == ST_ALARME);
`ifdef ROLHA_WATCHDOG_EN
      falha_d       = (state_d == ST_FALHA);
`endif
      garrafas_d    = garrafas_q;
      if (state_q == ST_DECREMENTA && garrafas_q != 16'hFFFF) begin
         garrafas_d = garrafas_q + 16'd1;
      end
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q       <= ST_IDLE;
         sensor_prev_q <= 1'b0;
         garrafas_q    <= '0;
         cnt_enable_q  <= 1'b0;
         cnt_load_q    <= 1'b0;
         cnt_dados_q   <= '0;
         motor_q       <= 1'b0;
         atuador_q     <= 1'b0;
         alarme_q      <= 1'b0;
`ifdef ROLHA_WATCHDOG_EN
         falha_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         sensor_prev_q <= sensor_prev_d;
         garrafas_q    <= garrafas_d;
         cnt_enable_q  <= cnt_enable_d;
         cnt_load_q    <= cnt_load_d;
         cnt_dados_q   <= cnt_dados_d;
         motor_q       <= motor_d;
         atuador_q     <= atuador_d;
         alarme_q      <= alarme_d;
`ifdef ROLHA_WATCHDOG_EN
         falha_q       <= falha_d;
`endif
      end
   end

   assign bus.CNT_ENABLE    = cnt_enable_q;
   assign bus.CNT_LOAD      = cnt_load_q;
   assign bus.CNT_DADOS     = cnt_dados_q;
   assign bus.MOTOR_ESTEIRA = motor_q;
   assign bus.ATUADOR       = atuador_q;
   assign bus.ALARME        = alarme_q;
   assign bus.GARRAFAS_OK   = garrafas_q;
`ifdef ROLHA_WATCHDOG_EN
   assign bus.FALHA         = falha_q;
`else
   assign bus.FALHA         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rolhadora_controller.sv
// ============================================================================
// tb_rolhadora_controller : bench with cork-stock counter model and scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rolhadora_controller;
   import rolhadora_pkg::*;

   logic CLOCK = 1'b0;
   logic RESET = 1'b1;
   always #5 CLOCK = ~CLOCK;

   rolhadora_controller_if bus ();

   rolhadora_controller dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus)
   );

   // Cork-stock counter owned by the station, not reset by the controller
   logic [6:0] cnt     = 7'd99;
   logic       pre_en  = 1'b0;
   logic [6:0] pre_val = 7'd0;
   always @(posedge CLOCK) begin
      if (pre_en)                          cnt <= pre_val;
      else if (bus.CNT_LOAD)               cnt <= bus.CNT_DADOS;
      else if (bus.CNT_ENABLE && cnt != 0) cnt <= cnt - 7'd1;
   end
   assign bus.CNT_ZERO = (cnt == 7'd0);

   // Free-running event monitor, read by snapshot differences
   int         mon_atu_hi = 0, mon_atu_rise = 0, mon_en = 0, mon_load = 0, mon_viol = 0;
   logic [6:0] mon_dados = 7'd0;
   logic       atu_prev = 1'b0;
   always @(negedge CLOCK) begin
      if (bus.ATUADOR) mon_atu_hi <= mon_atu_hi + 1;
      if (bus.ATUADOR && !atu_prev) mon_atu_rise <= mon_atu_rise + 1;
      atu_prev <= bus.ATUADOR;
      if (bus.CNT_ENABLE) mon_en <= mon_en + 1;
      if (bus.CNT_LOAD) begin
         mon_load  <= mon_load + 1;
         mon_dados <= bus.CNT_DADOS;
      end
      if ((bus.CNT_ENABLE && bus.CNT_LOAD) || (!bus.CNT_LOAD && bus.CNT_DADOS != 7'd0))
         mon_viol <= mon_viol + 1;
   end

   int checks = 0;
   int errors = 0;
   int m_stock = 99;
   int m_ok    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #2;
   endtask

   function automatic logic [6:0] refill_value(input logic [6:0] q);
      return (q == 7'd0 || q > 7'd99) ? 7'd99 : q;
   endfunction

   // Scoreboard: a bottle is corked when stock is available and the sensor was
   // high for the detecting edge plus the full settle time.
   function automatic bit model_step(input bit refill, input logic [6:0] q, input int dur);
      bit corked;
      if (refill) m_stock = int'(refill_value(q));
      corked = (m_stock != 0) && (dur > SETTLE_CYCLES);
      if (corked) begin
         m_stock = m_stock - 1;
         if (m_ok != 65535) m_ok = m_ok + 1;
      end
      return corked;
   endfunction

   task automatic apply(input string name, input bit refill, input logic [6:0] qtd,
                        input int dur, input int gap, input int e_atu, input int e_en,
                        input int e_load, input logic [6:0] e_dados);
      int s_hi, s_rise, s_en, s_load, s_viol;
      s_hi = mon_atu_hi; s_rise = mon_atu_rise; s_en = mon_en;
      s_load = mon_load; s_viol = mon_viol;
      if (refill) begin
         bus.QTD_REPOR = qtd;
         bus.REPOR     = 1'b1;
         tick();
         bus.REPOR     = 1'b0;
         repeat (4) tick();
      end
      bus.SENSOR_GARRAFA = 1'b1;
      repeat (dur) tick();
      bus.SENSOR_GARRAFA = 1'b0;
      repeat (gap) tick();
      chk({name, " atuador_cycles"}, 32'(mon_atu_hi - s_hi), 32'(e_atu));
      chk({name, " atuador_pulses"}, 32'(mon_atu_rise - s_rise), (e_atu != 0) ? 32'd1 : 32'd0);
      chk({name, " enable_pulses"}, 32'(mon_en - s_en), 32'(e_en));
      chk({name, " load_pulses"}, 32'(mon_load - s_load), 32'(e_load));
      if (e_load != 0) chk({name, " dados"}, 32'(mon_dados), 32'(e_dados));
      chk({name, " strobe_rules"}, 32'(mon_viol - s_viol), 32'd0);
      chk({name, " counter"}, 32'(cnt), 32'(m_stock));
      chk({name, " garrafas_ok"}, 32'(bus.GARRAFAS_OK), 32'(m_ok));
      chk({name, " alarme"}, 32'(bus.ALARME), (m_stock == 0) ? 32'd1 : 32'd0);
      chk({name, " motor"}, 32'(bus.MOTOR_ESTEIRA), (m_stock != 0) ? 32'd1 : 32'd0);
   endtask

   typedef struct {
      bit         refill;
      logic [6:0] qtd;
      int         dur;
      int         e_atu;
      int         e_en;
      int         e_load;
      logic [6:0] e_dados;
   } vec_t;

   vec_t vecs[8];

   initial begin
      bit         corked, rf;
      logic [6:0] q;
      int         dur, gap, s_load, s_en;
      logic [6:0] cnt_before;

      vecs[0] = '{0, 7'd0,   2,  0, 0, 0, 7'd0};   // glitch
      vecs[1] = '{0, 7'd0,   20, 8, 1, 0, 7'd0};   // normal bottle
      vecs[2] = '{0, 7'd0,   4,  0, 0, 0, 7'd0};   // one short of settle
      vecs[3] = '{0, 7'd0,   5,  8, 1, 0, 7'd0};   // just settled
      vecs[4] = '{1, 7'd0,   1,  0, 0, 1, 7'd99};
      vecs[5] = '{1, 7'd120, 30, 8, 1, 1, 7'd99};
      vecs[6] = '{1, 7'd100, 6,  8, 1, 1, 7'd99};
      vecs[7] = '{1, 7'd1,   3,  0, 0, 1, 7'd1};

      bus.SENSOR_GARRAFA = 1'b0;
      bus.REPOR          = 1'b0;
      bus.QTD_REPOR      = 7'd0;

      repeat (3) tick();
      chk("reset motor",    32'(bus.MOTOR_ESTEIRA), 32'd0);
      chk("reset atuador",  32'(bus.ATUADOR), 32'd0);
      chk("reset strobes",  32'({bus.CNT_ENABLE, bus.CNT_LOAD, bus.ALARME, bus.FALHA}), 32'd0);
      chk("reset dados",    32'(bus.CNT_DADOS), 32'd0);
      chk("reset garrafas", 32'(bus.GARRAFAS_OK), 32'd0);
      RESET = 1'b0;
      tick();
      chk("motor after reset", 32'(bus.MOTOR_ESTEIRA), 32'd1);
      repeat (3) tick();

      for (int i = 0; i < 8; i++) begin
         corked = model_step(vecs[i].refill, vecs[i].qtd, vecs[i].dur);
         apply($sformatf("vec%0d", i), vecs[i].refill, vecs[i].qtd, vecs[i].dur, 20,
               vecs[i].e_atu, vecs[i].e_en, vecs[i].e_load, vecs[i].e_dados);
      end

      // Stock of one: the second bottle is refused and the line stops
      pre_val = 7'd1; pre_en = 1'b1; tick(); pre_en = 1'b0; tick();
      m_stock = 1;
      corked = model_step(0, 7'd0, 20);
      apply("last_cork", 0, 7'd0, 20, 20, 8, 1, 0, 7'd0);
      corked = model_step(0, 7'd0, 20);
      apply("empty_bottle", 0, 7'd0, 20, 20, 0, 0, 0, 7'd0);
      corked = model_step(1, 7'd50, 20);
      apply("refill50", 1, 7'd50, 20, 20, 8, 1, 1, 7'd50);

      // REPOR during ARROLHA must not produce a load
      s_load = mon_load; s_en = mon_en;
      bus.QTD_REPOR = 7'd10;
      bus.SENSOR_GARRAFA = 1'b1;
      repeat (7) tick();
      chk("arrolha reached", 32'(bus.ATUADOR), 32'd1);
      bus.REPOR = 1'b1;
      repeat (3) tick();
      bus.REPOR = 1'b0;
      repeat (10) tick();
      bus.SENSOR_GARRAFA = 1'b0;
      repeat (20) tick();
      corked = model_step(0, 7'd0, 20);
      chk("repor_in_arrolha load", 32'(mon_load - s_load), 32'd0);
      chk("repor_in_arrolha enable", 32'(mon_en - s_en), 32'd1);
      chk("repor_in_arrolha counter", 32'(cnt), 32'(m_stock));

      for (int n = 0; n < 40; n++) begin
         rf  = ($urandom_range(0, 3) == 0);
         q   = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127));
         dur = $urandom_range(1, 30);
         gap = $urandom_range(18, 30);
         corked = model_step(rf, q, dur);
         apply($sformatf("rnd%0d", n), rf, q, dur, gap, corked ? 8 : 0, corked ? 1 : 0,
               rf ? 1 : 0, refill_value(q));
      end

      corked = model_step(1, 7'd10, 1);
      apply("prep", 1, 7'd10, 1, 20, 0, 0, 1, 7'd10);

      // Asynchronous reset in the middle of corking
      cnt_before = cnt;
      bus.SENSOR_GARRAFA = 1'b1;
      repeat (8) tick();
      chk("pre-reset atuador", 32'(bus.ATUADOR), 32'd1);
      #1 RESET = 1'b1;
      #1;
      chk("async reset atuador", 32'(bus.ATUADOR), 32'd0);
      chk("async reset garrafas", 32'(bus.GARRAFAS_OK), 32'd0);
      chk("async reset motor", 32'(bus.MOTOR_ESTEIRA), 32'd0);
      bus.SENSOR_GARRAFA = 1'b0;
      tick(); tick();
      RESET = 1'b0;
      tick();
      m_ok = 0;
      chk("counter kept over reset", 32'(cnt), 32'(cnt_before));
      chk("motor after mid reset", 32'(bus.MOTOR_ESTEIRA), 32'd1);
      repeat (3) tick();

      // Bottle stuck under the press exit
      bus.SENSOR_GARRAFA = 1'b1;
      repeat (300) tick();
      corked = model_step(0, 7'd0, 300);
`ifdef ROLHA_WATCHDOG_EN
      chk("wdog falha", 32'(bus.FALHA), 32'd1);
      chk("wdog motor", 32'(bus.MOTOR_ESTEIRA), 32'd0);
      chk("wdog atuador", 32'(bus.ATUADOR), 32'd0);
      bus.SENSOR_GARRAFA = 1'b0;
      repeat (10) tick();
      chk("wdog falha held", 32'(bus.FALHA), 32'd1);
      chk("wdog motor held", 32'(bus.MOTOR_ESTEIRA), 32'd0);
      RESET = 1'b1;
      tick();
      chk("wdog falha cleared", 32'(bus.FALHA), 32'd0);
      RESET = 1'b0;
      tick();
      m_ok = 0;
      chk("wdog motor after reset", 32'(bus.MOTOR_ESTEIRA), 32'd1);
`else
      chk("no-wdog falha", 32'(bus.FALHA), 32'd0);
      chk("no-wdog motor", 32'(bus.MOTOR_ESTEIRA), 32'd1);
      bus.SENSOR_GARRAFA = 1'b0;
      repeat (10) tick();
      chk("no-wdog falha after", 32'(bus.FALHA), 32'd0);
`endif
      chk("stuck counter", 32'(cnt), 32'(m_stock));
      chk("stuck garrafas", 32'(bus.GARRAFAS_OK), 32'(m_ok));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
